// File: rtl/sram_slave_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_slave_port_pkg
// Purpose  : Shared constants and helpers for the SRAM-style data port
//            responder: config window base, register offsets, RAM size
//            default and a byte-lane merge function.
// Revision : 1.0 - initial release
// ============================================================================
package sram_slave_port_pkg;

    localparam int          C_RAM_AW_DEFAULT = 14;
    localparam logic [15:0] C_CONF_HI        = 16'hbfaf;

    // Offsets inside the config window (sram_addr[15:0])
    localparam logic [15:0] C_LED_OFF    = 16'hf000;
    localparam logic [15:0] C_SWITCH_OFF = 16'hf004;
    localparam logic [15:0] C_NUM_OFF    = 16'hf010;
    localparam logic [15:0] C_TIMER_OFF  = 16'he000;

    // Replace only the bytes whose write-enable bit is set.
    function automatic logic [31:0] f_byte_merge(
        input logic [31:0] i_old,
        input logic [31:0] i_new,
        input logic [3:0]  i_wen
    );
        logic [31:0] w_res;
        w_res = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_wen[b]) begin
                w_res[b*8 +: 8] = i_new[b*8 +: 8];
            end
        end
        return w_res;
    endfunction

endpackage : sram_slave_port_pkg
`default_nettype wire

// File: rtl/sram_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : sram_slave_ram
// Purpose  : Single-port 2^RAM_AW x 32 data RAM with byte write enables and
//            a registered read output. Contents and output are not reset.
// Ports    : clk      - clock
//            i_wr     - write strobe (already qualified by the caller)
//            i_rd     - read strobe; o_rdata updates on this edge only
//            i_wen    - byte write enables
//            i_idx    - word index
//            i_wdata  - write data
//            o_rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module sram_slave_ram
    import sram_slave_port_pkg::*;
#(
    parameter int RAM_AW = C_RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [3:0]        i_wen,
    input  logic [RAM_AW-1:0] i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**RAM_AW];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wen[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_rd) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sram_slave_ram
`default_nettype wire

// File: rtl/sram_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : sram_slave_port
// Purpose  : Responder for the core's SRAM-style data port. Decodes each
//            request into either the on-chip data RAM or a small config
//            register window (LED, switches, 7-seg number, timer). Reads
//            return one cycle later; writes honour byte enables.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            sram_en/wen/addr/wdata - request from the core
//            sram_rdata             - registered read data (1-cycle latency)
//            switch_in              - board switches
//            led_out, num_out       - config registers
//            timer_out              - free-running timer, zero-extended
// Revision : 1.0 - initial release
// ============================================================================
module sram_slave_port
    import sram_slave_port_pkg::*;
#(
    parameter int          RAM_AW  = C_RAM_AW_DEFAULT,
    parameter logic [15:0] CONF_HI = C_CONF_HI,
    parameter int          TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out,
    output logic [31:0] timer_out
);

    logic              w_conf_sel;
    logic [15:0]       w_off;
    logic              w_wr;
    logic              w_rd;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_conf_rdata;
    logic [31:0]       w_timer_ext;
    logic [31:0]       w_timer_merged;
    logic [31:0]       w_led_merged;
    logic [31:0]       w_num_merged;

    logic [15:0]        r_led;
    logic [31:0]        r_num;
    logic [TIMER_W-1:0] r_timer;
    logic [31:0]        r_conf_rdata;
    logic               r_conf_sel_q;

    assign w_conf_sel = (sram_addr[31:16] == CONF_HI);
    assign w_off      = sram_addr[15:0];
    assign w_wr       = sram_en && (sram_wen != 4'b0000);
    assign w_rd       = sram_en && (sram_wen == 4'b0000);

    // Reset discards the request of its cycle, so RAM strobes are gated too.
    sram_slave_ram #(
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_wr    (w_wr && !w_conf_sel && !reset),
        .i_rd    (w_rd && !w_conf_sel && !reset),
        .i_wen   (sram_wen),
        .i_idx   (sram_addr[RAM_AW+1:2]),
        .i_wdata (sram_wdata),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (TIMER_W < 32) begin : g_timer_pad
            logic w_unused_timer;
            assign w_timer_ext    = {{(32-TIMER_W){1'b0}}, r_timer};
            assign w_unused_timer = &{1'b0, w_timer_merged[31:TIMER_W]};
        end else begin : g_timer_full
            assign w_timer_ext = r_timer;
        end
    endgenerate

    assign timer_out      = w_timer_ext;
    assign w_timer_merged = f_byte_merge(w_timer_ext, sram_wdata, sram_wen);
    assign w_led_merged   = f_byte_merge({16'h0000, r_led}, sram_wdata, sram_wen);
    assign w_num_merged   = f_byte_merge(r_num, sram_wdata, sram_wen);

    always_comb begin
        w_conf_rdata = 32'h0000_0000;
        case (w_off)
            C_LED_OFF:    w_conf_rdata = {16'h0000, r_led};
            C_SWITCH_OFF: w_conf_rdata = {16'h0000, switch_in};
            C_NUM_OFF:    w_conf_rdata = r_num;
            C_TIMER_OFF:  w_conf_rdata = w_timer_ext;
            default:      w_conf_rdata = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led        <= 16'h0000;
            r_num        <= 32'h0000_0000;
            r_timer      <= '0;
            r_conf_rdata <= 32'h0000_0000;
            // Point the output mux at the zeroed config register so
            // sram_rdata reads 0 without depending on RAM contents.
            r_conf_sel_q <= 1'b1;
        end else begin
            if (w_wr && w_conf_sel && (w_off == C_TIMER_OFF)) begin
                r_timer <= w_timer_merged[TIMER_W-1:0];
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end

            if (w_wr && w_conf_sel && (w_off == C_LED_OFF)) begin
                r_led <= w_led_merged[15:0];
            end
            if (w_wr && w_conf_sel && (w_off == C_NUM_OFF)) begin
                r_num <= w_num_merged;
            end

            if (w_rd) begin
                r_conf_sel_q <= w_conf_sel;
                if (w_conf_sel) begin
                    r_conf_rdata <= w_conf_rdata;
                end
            end
        end
    end

    // Both sources only change on reads of their own kind, and the select
    // only changes on reads, so the mux output holds between reads.
    assign sram_rdata = r_conf_sel_q ? r_conf_rdata : w_ram_rdata;
    assign led_out    = r_led;
    assign num_out    = r_num;

    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, sram_addr[1:0]};

endmodule : sram_slave_port
`default_nettype wire

// File: tb/tb_sram_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_slave_port
// Purpose  : Directed self-checking bench for sram_slave_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_slave_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;
    logic [31:0] timer_out;

    int total = 0;
    int bad   = 0;

    sram_slave_port dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .switch_in  (switch_in),
        .led_out    (led_out),
        .num_out    (num_out),
        .timer_out  (timer_out)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        sram_en = 1'b1; sram_wen = w; sram_addr = a; sram_wdata = d;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = a; sram_wdata = 32'h0;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        switch_in = 16'h0000;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        total++;
        if (timer_out !== 32'd0 || led_out !== 16'h0 || num_out !== 32'h0 || sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: timer=%h led=%h num=%h rdata=%h, want all 0",
                     timer_out, led_out, num_out, sram_rdata);
        end
        rd(32'hbfaf_f000);
        total++;
        if (sram_rdata !== 32'h0 || timer_out !== 32'd1) begin
            bad++;
            $display("FAIL reset_led_read: rdata=%h timer=%h, want 0 / 1", sram_rdata, timer_out);
        end
        cyc();
        total++;
        if (timer_out !== 32'd2) begin
            bad++;
            $display("FAIL timer_count: got %h want 2", timer_out);
        end
    endtask

    task automatic test_byte_write();
        wr(32'h0000_0010, 32'h1234_5678, 4'b1111);
        wr(32'h0000_0010, 32'h0000_AB00, 4'b0010);
        rd(32'h0000_0010);
        total++;
        if (sram_rdata !== 32'h1234_AB78) begin
            bad++;
            $display("FAIL ram_byte_merge: got %h want 1234ab78", sram_rdata);
        end
        // Write cycle must not disturb rdata.
        wr(32'h0000_0014, 32'h5555_5555, 4'b1111);
        total++;
        if (sram_rdata !== 32'h1234_AB78) begin
            bad++;
            $display("FAIL write_holds_rdata: got %h want 1234ab78", sram_rdata);
        end
        // Address bit 16 is above the index and aliases onto word 4.
        wr(32'h0001_0010, 32'h0BAD_F00D, 4'b1111);
        rd(32'h0000_0010);
        total++;
        if (sram_rdata !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL ram_alias: got %h want 0badf00d", sram_rdata);
        end
    endtask

    task automatic test_config();
        wr(32'hbfaf_f010, 32'hDEAD_BEEF, 4'b1111);
        total++;
        if (num_out !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL num_write: got %h want deadbeef", num_out);
        end
        rd(32'hbfaf_f010);
        total++;
        if (sram_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL num_read: got %h want deadbeef", sram_rdata);
        end
        switch_in = 16'h5A5A;
        wr(32'hbfaf_f004, 32'h0000_0001, 4'b1111);
        rd(32'hbfaf_f004);
        total++;
        if (sram_rdata !== 32'h0000_5A5A) begin
            bad++;
            $display("FAIL switch_read: got %h want 00005a5a", sram_rdata);
        end
        wr(32'hbfaf_f000, 32'hAAAA_1234, 4'b1111);
        wr(32'hbfaf_f000, 32'h00FF_0000, 4'b0100);
        total++;
        if (led_out !== 16'h1234) begin
            bad++;
            $display("FAIL led_lanes: got %h want 1234", led_out);
        end
        wr(32'hbfaf_f000, 32'h0000_9900, 4'b0010);
        rd(32'hbfaf_f000);
        total++;
        if (sram_rdata !== 32'h0000_9934 || led_out !== 16'h9934) begin
            bad++;
            $display("FAIL led_byte: rdata=%h led=%h want 00009934 / 9934", sram_rdata, led_out);
        end
    endtask

    task automatic test_timer();
        wr(32'hbfaf_e000, 32'hFFFF_FFFE, 4'b1111);
        total++;
        if (timer_out !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL timer_write: got %h want fffffffe", timer_out);
        end
        cyc();
        total++;
        if (timer_out !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL timer_max: got %h want ffffffff", timer_out);
        end
        cyc();
        total++;
        if (timer_out !== 32'h0) begin
            bad++;
            $display("FAIL timer_wrap: got %h want 0", timer_out);
        end
        wr(32'hbfaf_e000, 32'h0000_0100, 4'b1111);
        wr(32'hbfaf_e000, 32'h0000_0055, 4'b0001);
        total++;
        if (timer_out !== 32'h0000_0155) begin
            bad++;
            $display("FAIL timer_byte_write: got %h want 00000155", timer_out);
        end
        rd(32'hbfaf_e000);
        total++;
        if (sram_rdata !== 32'h0000_0155 || timer_out !== 32'h0000_0156) begin
            bad++;
            $display("FAIL timer_read: rdata=%h timer=%h want 00000155 / 00000156",
                     sram_rdata, timer_out);
        end
    endtask

    task automatic test_back_to_back();
        wr(32'h0000_0040, 32'hAAAA_0001, 4'b1111);
        wr(32'h0000_0044, 32'hBBBB_0002, 4'b1111);
        wr(32'h0000_0048, 32'hCCCC_0003, 4'b1111);
        sram_en = 1'b1; sram_wen = 4'b0000;
        sram_addr = 32'h0000_0040;
        cyc();
        total++;
        if (sram_rdata !== 32'hAAAA_0001) begin
            bad++;
            $display("FAIL b2b_0: got %h want aaaa0001", sram_rdata);
        end
        sram_addr = 32'h0000_0044;
        cyc();
        total++;
        if (sram_rdata !== 32'hBBBB_0002) begin
            bad++;
            $display("FAIL b2b_1: got %h want bbbb0002", sram_rdata);
        end
        sram_addr = 32'h0000_0048;
        cyc();
        total++;
        if (sram_rdata !== 32'hCCCC_0003) begin
            bad++;
            $display("FAIL b2b_2: got %h want cccc0003", sram_rdata);
        end
        sram_en   = 1'b0;
        sram_addr = 32'h0000_0040;
        cyc(); cyc();
        total++;
        if (sram_rdata !== 32'hCCCC_0003) begin
            bad++;
            $display("FAIL idle_hold: got %h want cccc0003", sram_rdata);
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        wr(32'h0000_0020, 32'h1111_1111, 4'b1111);
        wr(32'hbfaf_f010, 32'h0000_0077, 4'b1111);
        reset = 1'b1;
        sram_en = 1'b1; sram_wen = 4'b1111;
        sram_addr = 32'h0000_0020; sram_wdata = 32'hCAFE_F00D;
        cyc();
        idle();
        reset = 1'b0;
        total++;
        if (sram_rdata !== 32'h0 || num_out !== 32'h0 || timer_out !== 32'h0) begin
            bad++;
            $display("FAIL midstream_reset: rdata=%h num=%h timer=%h want 0",
                     sram_rdata, num_out, timer_out);
        end
        rd(32'h0000_0020);
        total++;
        if (sram_rdata !== 32'h1111_1111) begin
            bad++;
            $display("FAIL reset_drops_write: got %h want 11111111", sram_rdata);
        end
        wr(32'hbfaf_1234, 32'hFFFF_FFFF, 4'b1111);
        rd(32'hbfaf_1234);
        total++;
        if (sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_read: got %h want 0", sram_rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        switch_in = 16'h0;
        idle();
        test_reset();
        test_byte_write();
        test_config();
        test_timer();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_slave_port
`default_nettype wire
